color_bar_checker: RTL

COLOR_BAR_CHECKER -- requirements
Module: color_bar_checker

---
 rtl/color_bar_checker_pkg.sv | 41 ++++
 rtl/color_bar_column_tracker.sv | 82 ++++++++
 rtl/color_bar_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/color_bar_checker_pkg.sv
// ColorUtilities: bar palette, default bar count, FIFO word layout and checker
// state encoding shared by the color-bar checker files.
package ColorUtilities;

    localparam int NUM_COLOR_BARS_DEFAULT = 10;
    localparam int QWORD_W   = 17;
    localparam int SOF_BIT   = 16;
    localparam int RGB_W     = 16;
    localparam int BAR_IDX_W = 4;
    localparam int COL_W     = 10;
    localparam int ROW_W     = 9;
    localparam int PIX_CNT_W = 19;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } cbc_state_e;

    // RGB565 color of bar idx; indices past the palette read as black.
    function automatic logic [RGB_W-1:0] get_rgb_color(input logic [BAR_IDX_W-1:0] idx);
        logic [RGB_W-1:0] color;
        case (idx)
            4'd0:    color = 16'hFFFF;
            4'd1:    color = 16'hFFE0;
            4'd2:    color = 16'h07FF;
            4'd3:    color = 16'h07E0;
            4'd4:    color = 16'hF81F;
            4'd5:    color = 16'hF800;
            4'd6:    color = 16'h001F;
            4'd7:    color = 16'h0000;
            4'd8:    color = 16'h8410;
            4'd9:    color = 16'hFD20;
            default: color = 16'h0000;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/color_bar_column_tracker.sv
// Column, bar-index and row-wrap tracking for the color-bar checker; the bar
// index is stepped by an in-bar sub-counter so no divider is needed.
module color_bar_column_tracker
    import ColorUtilities::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int NUM_COLOR_BARS = NUM_COLOR_BARS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_advance,
    output logic [COL_W-1:0]     o_col,
    output logic [BAR_IDX_W-1:0] o_bar,
    output logic                 o_wrap
);
    localparam int BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_SUB = COL_W'(BAR_WIDTH - 1);

    logic [COL_W-1:0]     r_col;
    logic [COL_W-1:0]     r_sub;
    logic [BAR_IDX_W-1:0] r_bar;
    logic [COL_W-1:0]     w_col_base;
    logic [COL_W-1:0]     w_sub_base;
    logic [BAR_IDX_W-1:0] w_bar_base;
    logic [COL_W-1:0]     w_col_nxt;
    logic [COL_W-1:0]     w_sub_nxt;
    logic [BAR_IDX_W-1:0] w_bar_nxt;

    // Next position; clear and advance together land on column 1 of a fresh row.
    always_comb begin
        w_col_base = r_col;
        w_sub_base = r_sub;
        w_bar_base = r_bar;
        if (i_clear) begin
            w_col_base = '0;
            w_sub_base = '0;
            w_bar_base = '0;
        end else begin
            w_col_base = r_col;
            w_sub_base = r_sub;
            w_bar_base = r_bar;
        end

        w_col_nxt = w_col_base;
        w_sub_nxt = w_sub_base;
        w_bar_nxt = w_bar_base;
        if (!i_advance) begin
            w_col_nxt = w_col_base;
        end else if (w_col_base == LAST_COL) begin
            w_col_nxt = '0;
            w_sub_nxt = '0;
            w_bar_nxt = '0;
        end else if (w_sub_base == LAST_SUB) begin
            w_col_nxt = w_col_base + COL_W'(1);
            w_sub_nxt = '0;
            w_bar_nxt = w_bar_base + BAR_IDX_W'(1);
        end else begin
            w_col_nxt = w_col_base + COL_W'(1);
            w_sub_nxt = w_sub_base + COL_W'(1);
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_sub <= '0;
            r_bar <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_sub <= w_sub_nxt;
            r_bar <= w_bar_nxt;
        end
    end

    assign o_col  = r_col;
    assign o_bar  = r_bar;
    assign o_wrap = (r_col == LAST_COL);

endmodule

// File: rtl/color_bar_checker.sv
// Checks a FIFO-fed RGB565 color-bar frame and reports error/pixel/row counts.
// Define COLOR_BAR_CHECKER_ERR_CAPTURE_EN to latch the first error of each frame.
module color_bar_checker
    import ColorUtilities::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int NUM_COLOR_BARS = NUM_COLOR_BARS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [QWORD_W-1:0]   queue_data,
    input  logic                 queue_empty,
    output logic                 queue_rd_en,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic [PIX_CNT_W-1:0] pixel_count,
    output logic [ROW_W-1:0]     row_count,
    output logic [ROW_W-1:0]     err_row,
    output logic [COL_W-1:0]     err_col,
    output logic [RGB_W-1:0]     err_expected,
    output logic [RGB_W-1:0]     err_actual
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_HEIGHT - 1);

    cbc_state_e           r_state;
    logic                 r_valid;
    logic                 r_frame_done;
    logic                 r_frame_ok;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [PIX_CNT_W-1:0] r_pix_cnt;
    logic [ROW_W-1:0]     r_row_cnt;

    logic [COL_W-1:0]     w_col;
    logic [BAR_IDX_W-1:0] w_bar;
    logic                 w_wrap;
    logic                 w_sof;
    logic [RGB_W-1:0]     w_pix;
    logic [RGB_W-1:0]     w_expected;
    logic                 w_mismatch;
    logic                 w_start;
    logic                 w_take_sync;
    logic                 w_take_run;
    logic                 w_consume;
    logic                 w_restart;
    logic                 w_last;
    logic                 w_rd_en;
    logic [ERR_CNT_W:0]   w_err_sum;
    logic [ERR_CNT_W-1:0] w_err_nxt;

    assign w_sof       = queue_data[SOF_BIT];
    assign w_pix       = queue_data[RGB_W-1:0];
    assign w_expected  = get_rgb_color(w_bar);
    assign w_start     = (r_state == ST_IDLE) && enable;
    assign w_take_sync = (r_state == ST_SYNC) && r_valid && w_sof;
    assign w_take_run  = (r_state == ST_RUN) && r_valid;
    assign w_consume   = w_take_sync || w_take_run;
    assign w_mismatch  = w_consume && (w_pix != w_expected);
    assign w_restart   = w_take_run && w_sof && !((w_col == '0) && (r_row_cnt == '0));
    assign w_last      = w_take_run && !w_restart && w_wrap && (r_row_cnt == LAST_ROW);
    // At most one read is ever in flight, so no read may follow the last pixel's arrival.
    assign w_rd_en     = ((r_state == ST_SYNC) || (r_state == ST_RUN)) && !queue_empty && !w_last;
    assign w_err_sum   = {1'b0, r_err_cnt} + {16'd0, w_mismatch} + {16'd0, w_restart};
    assign w_err_nxt   = w_err_sum[ERR_CNT_W] ? 16'hFFFF : w_err_sum[ERR_CNT_W-1:0];

    color_bar_column_tracker #(
        .FRAME_WIDTH    (FRAME_WIDTH),
        .NUM_COLOR_BARS (NUM_COLOR_BARS)
    ) u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_start || w_restart),
        .i_advance (w_consume),
        .o_col     (w_col),
        .o_bar     (w_bar),
        .o_wrap    (w_wrap)
    );

    // Control FSM with the read-valid pipeline flag and frame result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
        end else begin
            r_valid      <= w_rd_en;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state    <= ST_SYNC;
                        r_frame_ok <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (w_take_sync) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b1;
                    r_frame_ok   <= (r_err_cnt == 16'd0);
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame counters; a stray SOF restarts position counts but keeps errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
            r_pix_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_start) begin
            r_err_cnt <= '0;
            r_pix_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_consume) begin
            r_err_cnt <= w_err_nxt;
            if (w_restart) begin
                r_pix_cnt <= 19'd1;
                r_row_cnt <= 9'd0;
            end else begin
                r_pix_cnt <= r_pix_cnt + 19'd1;
                r_row_cnt <= w_wrap ? (r_row_cnt + 9'd1) : r_row_cnt;
            end
        end
    end

    assign queue_rd_en = w_rd_en;
    assign frame_done  = r_frame_done;
    assign frame_ok    = r_frame_ok;
    assign error_count = r_err_cnt;
    assign pixel_count = r_pix_cnt;
    assign row_count   = r_row_cnt;

`ifdef COLOR_BAR_CHECKER_ERR_CAPTURE_EN
    logic             r_err_seen;
    logic [ROW_W-1:0] r_err_row;
    logic [COL_W-1:0] r_err_col;
    logic [RGB_W-1:0] r_err_exp;
    logic [RGB_W-1:0] r_err_act;

    // First-error capture, position taken before any restart takes effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_seen <= 1'b0;
            r_err_row  <= '0;
            r_err_col  <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
        end else if (w_start) begin
            r_err_seen <= 1'b0;
            r_err_row  <= '0;
            r_err_col  <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
        end else if ((w_mismatch || w_restart) && !r_err_seen) begin
            r_err_seen <= 1'b1;
            r_err_row  <= r_row_cnt;
            r_err_col  <= w_col;
            r_err_exp  <= w_expected;
            r_err_act  <= w_pix;
        end
    end

    assign err_row      = r_err_row;
    assign err_col      = r_err_col;
    assign err_expected = r_err_exp;
    assign err_actual   = r_err_act;
`else
    assign err_row      = '0;
    assign err_col      = '0;
    assign err_expected = '0;
    assign err_actual   = '0;
`endif

endmodule
